// File: rtl/abs_diff_pkg.sv
// abs_diff_pkg: shared types and helpers for the approximate |a-b| pipeline.
//   mode_e     : per-transaction approximation mode
//   ones       : w-bit all-ones mask in a MAX_W container
//   approx_fn  : exact result -> approximate result for a given mode
//   sat_inc    : w-bit saturating increment
// Helpers work on a MAX_W-bit container so one function serves every WIDTH;
// callers narrow the result back with a size cast.
package abs_diff_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_TRUNC = 2'd1,
    MODE_FORCE = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] ones(input int w);
    // w=0 shifts everything out and yields an empty mask
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

  function automatic logic [MAX_W-1:0] approx_fn(input logic [MAX_W-1:0] exact,
                                                 input mode_e mode,
                                                 input int drop,
                                                 input int width);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] res;
    mask = ones(drop);
    res  = exact;
    case (mode)
      MODE_TRUNC: res = exact & ~mask;
      MODE_FORCE: res = exact | mask;
      MODE_CONST: res = ones(width);
      default:    res = exact;
    endcase
    return res;
  endfunction

  function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v, input int w);
    return (v == ones(w)) ? v : v + MAX_W'(1);
  endfunction

endpackage

// File: rtl/abs_diff_err_monitor.sv
// abs_diff_err_monitor: saturating error statistics for the result stream.
//   clk, rst  : clock, async active-high reset
//   xfer      : a result is transferred this cycle
//   err, flag : error magnitude and threshold-violation flag of that result
//   clear     : synchronous clear; a coincident transfer still counts
//   samples, viol, max_err : statistics since the last clear
module abs_diff_err_monitor
  import abs_diff_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             xfer,
  input  logic [WIDTH-1:0] err,
  input  logic             flag,
  input  logic             clear,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] viol,
  output logic [WIDTH-1:0] max_err
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samples <= '0;
      viol    <= '0;
      max_err <= '0;
    end else if (clear) begin
      // clear restarts the window; the transfer of this cycle opens it
      samples <= xfer ? CNT_W'(1) : '0;
      viol    <= (xfer && flag) ? CNT_W'(1) : '0;
      max_err <= xfer ? err : '0;
    end else if (xfer) begin
      samples <= CNT_W'(sat_inc(MAX_W'(samples), CNT_W));
      if (flag) viol <= CNT_W'(sat_inc(MAX_W'(viol), CNT_W));
      if (err > max_err) max_err <= err;
    end
  end

endmodule

// File: rtl/abs_diff_approx_pipe.sv
// abs_diff_approx_pipe: 2-stage elastic |a-b| with selectable approximation
// and an on-line error monitor.
//   clk, rst                     : clock, async active-high reset
//   in_valid/in_ready, in_a/b    : operand handshake, unsigned WIDTH-bit
//   in_mode                      : mode_e for this transaction
//   out_valid/out_ready          : result handshake
//   out_diff, out_err_flag       : approximate result, err > ET
//   stat_clear, stat_*           : statistics clear and counters
module abs_diff_approx_pipe
  import abs_diff_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DROP_LSB = 1,
  parameter int ET       = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_err_flag,
  input  logic             stat_clear,
  output logic [CNT_W-1:0] stat_samples,
  output logic [CNT_W-1:0] stat_viol,
  output logic [WIDTH-1:0] stat_max_err
);

  localparam int STAGES = 2;
  localparam logic [MAX_W-1:0] ET_U = MAX_W'(ET);

  typedef struct packed {
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    mode_e             mode;
    logic signed [WIDTH:0] diff;
  } s1_t;

  logic [STAGES:1]  vld_pipe;
  s1_t              s1;
  logic [WIDTH-1:0] s2_err;
  logic             s1_adv, in_xfer, out_xfer;
  logic [WIDTH-1:0] exact, approx, err;
  logic             flag;

  assign out_valid = vld_pipe[2];
  assign s1_adv    = !vld_pipe[2] | out_ready;
  assign in_ready  = !vld_pipe[1] | s1_adv;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = vld_pipe[2] & out_ready;

  // Negative difference: b-a is the magnitude and fits in WIDTH bits;
  // otherwise the low WIDTH bits of diff already are the magnitude.
  assign exact  = s1.diff[WIDTH] ? (s1.b - s1.a) : s1.diff[WIDTH-1:0];
  assign approx = WIDTH'(approx_fn(MAX_W'(exact), s1.mode, DROP_LSB, WIDTH));
  assign err    = (approx >= exact) ? (approx - exact) : (exact - approx);
  assign flag   = MAX_W'(err) > ET_U;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe     <= '0;
      s1           <= '0;
      out_diff     <= '0;
      out_err_flag <= 1'b0;
      s2_err       <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (in_xfer)
        s1 <= '{a: in_a, b: in_b, mode: mode_e'(in_mode),
                diff: $signed({1'b0, in_a}) - $signed({1'b0, in_b})};
      if (s1_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_diff     <= approx;
          out_err_flag <= flag;
          s2_err       <= err;
        end
      end
    end
  end

  abs_diff_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mon (
    .clk     (clk),
    .rst     (rst),
    .xfer    (out_xfer),
    .err     (s2_err),
    .flag    (out_err_flag),
    .clear   (stat_clear),
    .samples (stat_samples),
    .viol    (stat_viol),
    .max_err (stat_max_err)
  );

endmodule

// File: tb/tb_abs_diff_approx_pipe.sv
module tb_abs_diff_approx_pipe;
  localparam int W = 4, D = 1, ET = 4;

  logic clk = 0, rst = 1;
  logic in_valid = 0, out_ready = 0, stat_clear = 0;
  logic [W-1:0] in_a = 0, in_b = 0;
  logic [1:0] in_mode = 0;
  logic in_ready, out_valid, out_err_flag;
  logic [W-1:0] out_diff, stat_max_err;
  logic [15:0] stat_samples, stat_viol;
  logic in_ready2, out_valid2, out_err_flag2;
  logic [W-1:0] out_diff2, stat_max_err2;
  logic [1:0] stat_samples2, stat_viol2;

  always #5 clk = ~clk;

  abs_diff_approx_pipe #(.WIDTH(W), .DROP_LSB(D), .ET(ET), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_diff(out_diff), .out_err_flag(out_err_flag),
    .stat_clear(stat_clear), .stat_samples(stat_samples), .stat_viol(stat_viol),
    .stat_max_err(stat_max_err));

  // narrow-counter copy for saturation behaviour
  abs_diff_approx_pipe #(.WIDTH(W), .DROP_LSB(D), .ET(ET), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid2),
    .out_ready(out_ready), .out_diff(out_diff2), .out_err_flag(out_err_flag2),
    .stat_clear(stat_clear), .stat_samples(stat_samples2), .stat_viol(stat_viol2),
    .stat_max_err(stat_max_err2));

  typedef struct { int d; int e; int acc; } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_acc = 0;
  int smp[2] = '{0, 0};
  int vio[2] = '{0, 0};
  int mx = 0;
  int sat_max[2] = '{65535, 3};

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference: |a-b| then the mode's rounding, all in plain integer arithmetic
  function automatic void ref_model(input int a, input int b, input int m,
                                    output int d, output int e);
    int exact, p;
    exact = (a > b) ? a - b : b - a;
    p = 2 ** D;
    case (m)
      0: d = exact;
      1: d = (exact / p) * p;
      2: d = (exact / p) * p + p - 1;
      default: d = 2 ** W - 1;
    endcase
    e = (d > exact) ? d - exact : exact - d;
  endfunction

  task automatic check_stats();
    check("samples", stat_samples, smp[0]);
    check("viol", stat_viol, vio[0]);
    check("max_err", stat_max_err, mx);
    check("samples_sat", stat_samples2, smp[1]);
    check("viol_sat", stat_viol2, vio[1]);
    check("max_err_sat", stat_max_err2, mx);
  endtask

  task automatic cycle(input bit v, input int a, input int b, input int m,
                       input bit ordy, input bit clr);
    bit ev, er, xfer, acc;
    int d, e;
    @(negedge clk);
    check_stats();
    in_valid = v; in_a = W'(a); in_b = W'(b); in_mode = 2'(m);
    out_ready = ordy; stat_clear = clr;
    #1;
    ev = (q.size() > 0) && (cyc - q[0].acc >= 2);
    er = (q.size() < 2) || ordy;
    check("in_ready", in_ready, er);
    check("out_valid", out_valid, ev);
    check("out_valid_sat", out_valid2, ev);
    if (ev) begin
      check("out_diff", out_diff, q[0].d);
      check("err_flag", out_err_flag, q[0].e > ET);
    end
    xfer = ev && ordy;
    acc  = v && er;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        smp[k] = xfer ? 1 : 0;
        vio[k] = (xfer && q[0].e > ET) ? 1 : 0;
      end else if (xfer) begin
        if (smp[k] < sat_max[k]) smp[k]++;
        if (q[0].e > ET && vio[k] < sat_max[k]) vio[k]++;
      end
    end
    if (clr) mx = xfer ? q[0].e : 0;
    else if (xfer && q[0].e > mx) mx = q[0].e;
    if (xfer) void'(q.pop_front());
    if (acc) begin
      ref_model(a, b, m, d, e);
      q.push_back('{d: d, e: e, acc: cyc});
      n_acc++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 1, 0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_diff", out_diff, 0);
    check("rst_err_flag", out_err_flag, 0);
    check("rst_samples", stat_samples, 0);
    check("rst_viol", stat_viol, 0);
    check("rst_max_err", stat_max_err, 0);
    check("rst_out_valid_sat", out_valid2, 0);
    q.delete(); smp = '{0, 0}; vio = '{0, 0}; mx = 0;
    in_valid = 0; stat_clear = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int a0;
    repeat (3) @(posedge clk);
    #1;
    check("init_out_valid", out_valid, 0);
    check("init_out_diff", out_diff, 0);
    check("init_samples", stat_samples, 0);
    check("init_max_err", stat_max_err, 0);
    @(negedge clk);
    rst = 0;

    // exact mode
    cycle(1, 9, 3, 0, 1, 0);
    idle(3);
    check("tp_exact_samples", stat_samples, 1);
    check("tp_exact_max", stat_max_err, 0);
    // truncate then force
    cycle(1, 2, 9, 1, 1, 0);
    cycle(1, 9, 3, 2, 1, 0);
    idle(3);
    check("tp_tf_viol", stat_viol, 0);
    check("tp_tf_max", stat_max_err, 1);
    // constant
    cycle(1, 5, 5, 3, 1, 0);
    idle(3);
    check("tp_const_viol", stat_viol, 1);
    check("tp_const_max", stat_max_err, 15);

    // back-pressure: only two entries fit
    cycle(0, 0, 0, 0, 1, 1);
    a0 = n_acc;
    for (int i = 0; i < 4; i++) cycle(1, i + 4, i, i, 0, 0);
    check("stall_accepted", n_acc - a0, 2);
    idle(4);

    // async reset with both stages full
    cycle(1, 12, 1, 0, 0, 0);
    cycle(1, 1, 12, 2, 0, 0);
    async_reset();
    idle(3);

    // saturation of the narrow counters, then clear with a coincident transfer
    cycle(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cycle(1, i, 2 * i, 0, 1, 0);
    idle(3);
    check("sat_samples", stat_samples2, 3);
    check("wide_samples", stat_samples, 5);
    cycle(1, 7, 7, 3, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1);
    idle(1);
    check("clr_xfer_samples", stat_samples2, 1);
    check("clr_xfer_viol", stat_viol2, 1);
    check("clr_xfer_max", stat_max_err2, 15);

    // random traffic
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 3), $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    idle(4);
    check("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
